// File: rtl/sat_div_16bit_if.sv
// Request/result bundle for the iterative signed divider.
// The master issues start with operands; the slave returns status and results.
interface sat_div_16bit_if #(
  parameter int WIDTH = 16
) ();
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/sat_div_16bit.sv
// Iterative signed restoring divider, one quotient bit per clock, with results
// saturated to the signed range (0x7FFF / 0x8000) like the saturating adder.
//
// state | meaning
// IDLE  | waiting for start; special cases resolve here directly to DONE
// CALC  | one restoring step per edge, WIDTH steps, busy high
// DONE  | done high for this single cycle, then back to IDLE
module sat_div_16bit #(
  parameter int WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  sat_div_16bit_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_p;
  logic [WIDTH-1:0] qd;
  logic [WIDTH-1:0] dsr_mag;
  logic             sign_q;
  logic             sign_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] rem_r;
  logic             dz_r;
  logic             ov_r;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             is_ovf;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             take;
  logic [WIDTH-1:0] next_rem;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] q_final;
  logic [WIDTH-1:0] r_final;

  // Magnitudes as unsigned: negating 0x8000 yields 0x8000 = 32768, as intended.
  always_comb begin
    a_mag  = bus.dividend[WIDTH-1] ? (~bus.dividend + 1'b1) : bus.dividend;
    b_mag  = bus.divisor[WIDTH-1]  ? (~bus.divisor  + 1'b1) : bus.divisor;
    is_ovf = (bus.dividend == MIN_NEG) && (bus.divisor == {WIDTH{1'b1}});
  end

  // The partial remainder is always below the divisor (<= 2^(WIDTH-1)), so the
  // 17-bit trial difference has its top bit set exactly when it went negative.
  always_comb begin
    shifted  = {rem_p, qd[WIDTH-1]};
    diff     = shifted - {1'b0, dsr_mag};
    take     = ~diff[WIDTH];
    next_rem = take ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    q_mag    = {qd[WIDTH-2:0], take};
    if (sign_q) begin
      q_final = ~q_mag + 1'b1;
    end else begin
      q_final = q_mag[WIDTH-1] ? MAX_POS : q_mag;
    end
    r_final  = sign_r ? (~next_rem + 1'b1) : next_rem;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      rem_p   <= '0;
      qd      <= '0;
      dsr_mag <= '0;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      quo_r   <= '0;
      rem_r   <= '0;
      dz_r    <= 1'b0;
      ov_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            dz_r <= 1'b0;
            ov_r <= 1'b0;
            if (bus.divisor == '0) begin
              quo_r  <= bus.dividend[WIDTH-1] ? MIN_NEG : MAX_POS;
              rem_r  <= bus.dividend;
              dz_r   <= 1'b1;
              done_r <= 1'b1;
              state  <= DONE;
            end else if (is_ovf) begin
              quo_r  <= MAX_POS;
              rem_r  <= '0;
              ov_r   <= 1'b1;
              done_r <= 1'b1;
              state  <= DONE;
            end else begin
              qd      <= a_mag;
              dsr_mag <= b_mag;
              rem_p   <= '0;
              cnt     <= '0;
              sign_q  <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
              sign_r  <= bus.dividend[WIDTH-1];
              busy_r  <= 1'b1;
              state   <= CALC;
            end
          end
        end
        CALC: begin
          rem_p <= next_rem;
          qd    <= q_mag;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            quo_r  <= q_final;
            rem_r  <= r_final;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = quo_r;
  assign bus.remainder   = rem_r;
  assign bus.div_by_zero = dz_r;
  assign bus.overflow    = ov_r;

endmodule
